// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: majority-vote bit sampling, start-glitch rejection, show-ahead receive FIFO.
// Define UART_RX_BREAK_EN to add break detection (break_det port and WAIT_IDLE state).
module uart_rx_param #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
`ifdef UART_RX_BREAK_EN
  ,
  output logic                          break_det
`endif
);

  localparam int DIV = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int WW  = DATA_BITS + 2;

  localparam logic [SW-1:0] SMP_LO   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SMP_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SMP_HI   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] SMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic          ODD      = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
`ifdef UART_RX_BREAK_EN
    , S_WAIT_IDLE
`endif
  } state_t;

  state_t               state;
  logic                 rx_meta, rx_sync, rx_prev;
  logic [1:0]           sync_vld;
  logic [DW-1:0]        div_cnt;
  logic [SW-1:0]        samp_cnt;
  logic                 s0, s1;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic                 par_err, frm_err;
  logic                 tick, fall, maj, decide, bit_end, last_stop, push_fire, push;
  logic [WW-1:0]        push_word;

  assign tick      = (div_cnt == DW'(DIV - 1));
  assign fall      = rx_prev & ~rx_sync;
  assign maj       = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);
  assign decide    = tick && (samp_cnt == SMP_HI);
  assign bit_end   = tick && (samp_cnt == SMP_LAST);
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
  assign push_fire = decide && (state == S_STOP) && last_stop;
  assign push_word = {frm_err | ~maj, par_err, shreg};

`ifdef UART_RX_BREAK_EN
  logic par_bit, brk;
  assign brk  = push_fire && (shreg == '0) && !par_bit && !maj;
  assign push = push_fire && !brk;
`else
  assign push = push_fire;
`endif

  // NOTE: every clocked block uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b0;
      sync_vld <= 2'b00;
      div_cnt  <= '0;
    end else begin
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      sync_vld <= {sync_vld[0], 1'b1};
      // The edge register only follows rx once the synchroniser holds real line data,
      // so a line already low at reset release never appears as a 1->0 edge.
      rx_prev  <= sync_vld[1] & rx_sync;
      if ((state == S_IDLE && fall) || tick) div_cnt <= '0;
      else                                   div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      samp_cnt <= '0;
      s0       <= 1'b0;
      s1       <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
`ifdef UART_RX_BREAK_EN
      par_bit   <= 1'b0;
      break_det <= 1'b0;
`endif
    end else begin
`ifdef UART_RX_BREAK_EN
      break_det <= 1'b0;
`endif
      if (state != S_IDLE && tick) begin
        samp_cnt <= (samp_cnt == SMP_LAST) ? '0 : samp_cnt + 1'b1;
        if (samp_cnt == SMP_LO)  s0 <= rx_sync;
        if (samp_cnt == SMP_MID) s1 <= rx_sync;
      end
      case (state)
        S_IDLE: if (fall) begin
          state    <= S_START;
          busy     <= 1'b1;
          samp_cnt <= '0;
        end
        S_START: begin
          if (decide && maj) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (bit_end) begin
            state    <= S_DATA;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
`ifdef UART_RX_BREAK_EN
            par_bit  <= 1'b0;
`endif
          end
        end
        S_DATA: begin
          if (decide) begin
            shreg   <= {maj, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (bit_end && bit_cnt == BW'(DATA_BITS)) state <= (PARITY != 0) ? S_PARITY : S_STOP;
        end
        S_PARITY: begin
          if (decide) begin
            par_err <= ^shreg ^ maj ^ ODD;
`ifdef UART_RX_BREAK_EN
            par_bit <= maj;
`endif
          end
          if (bit_end) state <= S_STOP;
        end
        S_STOP: if (decide) begin
          if (!maj) frm_err <= 1'b1;
          if (last_stop) begin
`ifdef UART_RX_BREAK_EN
            state     <= brk ? S_WAIT_IDLE : S_IDLE;
            busy      <= brk;
            break_det <= brk;
`else
            state <= S_IDLE;
            busy  <= 1'b0;
`endif
          end else begin
            stop_cnt <= 1'b1;
          end
        end
`ifdef UART_RX_BREAK_EN
        S_WAIT_IDLE: if (rx_sync) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
`endif
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, wr_en;
  logic [WW-1:0] head;

  assign rx_valid      = (count != '0);
  assign full          = (count == CW'(FIFO_DEPTH));
  assign pop           = rx_valid & rx_ready;
  assign wr_en         = push & (~full | pop);
  assign head          = mem[rd_ptr];
  assign rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
  assign rx_parity_err = rx_valid & head[DATA_BITS];
  assign rx_frame_err  = rx_valid & head[DATA_BITS+1];
  assign fifo_count    = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push & full & ~pop;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; nothing reads it unless rx_valid says the entry was written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_word;
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances (8N1, 8E1, 7O2 at 8x oversampling) with shortened bit periods.
// Break-detection scenarios are compiled in when UART_RX_BREAK_EN is defined.
module tb_uart_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [2:0] rx_v = 3'b111;
  logic [2:0] rdy = 3'b000;
  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic       pe0, fe0, v0, ov0, b0;
  logic       pe1, fe1, v1, ov1, b1;
  logic       pe2, fe2, v2, ov2, b2;
  logic [2:0] cnt0, cnt1;
  logic [1:0] cnt2;
`ifdef UART_RX_BREAK_EN
  logic brk0, brk1, brk2;
`endif

  // u0/u1: DIV = 4, 64 clocks per bit. u2: DIV = 4, 8x oversampling, 32 clocks per bit.
  uart_rx_param #(.CLK_HZ(4_000_000), .BAUD(62_500)) u0 (
    .clk(clk), .rst(rst), .rx(rx_v[0]), .rx_data(d0), .rx_parity_err(pe0), .rx_frame_err(fe0),
    .rx_valid(v0), .rx_ready(rdy[0]), .overrun(ov0), .fifo_count(cnt0), .busy(b0)
`ifdef UART_RX_BREAK_EN
    , .break_det(brk0)
`endif
  );

  uart_rx_param #(.CLK_HZ(4_000_000), .BAUD(62_500), .PARITY(1)) u1 (
    .clk(clk), .rst(rst), .rx(rx_v[1]), .rx_data(d1), .rx_parity_err(pe1), .rx_frame_err(fe1),
    .rx_valid(v1), .rx_ready(rdy[1]), .overrun(ov1), .fifo_count(cnt1), .busy(b1)
`ifdef UART_RX_BREAK_EN
    , .break_det(brk1)
`endif
  );

  uart_rx_param #(.CLK_HZ(4_000_000), .BAUD(125_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
                  .OVERSAMPLE(8), .FIFO_DEPTH(2)) u2 (
    .clk(clk), .rst(rst), .rx(rx_v[2]), .rx_data(d2), .rx_parity_err(pe2), .rx_frame_err(fe2),
    .rx_valid(v2), .rx_ready(rdy[2]), .overrun(ov2), .fifo_count(cnt2), .busy(b2)
`ifdef UART_RX_BREAK_EN
    , .break_det(brk2)
`endif
  );

  // Pop/pulse monitor for u0, plus stray-pulse counters for the other instances.
  logic [9:0] cap_q[$];
  logic       last_pop_busy = 1'b1;
  int         v0_cycles = 0, ov0_cycles = 0, other_ov = 0, brk_cycles = 0;
  always @(negedge clk) begin
    if (v0 && rdy[0]) begin
      cap_q.push_back({fe0, pe0, d0});
      last_pop_busy = b0;
    end
    if (v0) v0_cycles++;
    if (ov0) ov0_cycles++;
    if (ov1 || ov2) other_ov++;
`ifdef UART_RX_BREAK_EN
    if (brk0 || brk1 || brk2) brk_cycles++;
`endif
  end

  task automatic send(input int ch, input logic [7:0] data, input int nbits, input int par,
                      input int nstop, input logic [1:0] stops);
    int bc;
    bc = (ch == 2) ? 32 : 64;
    @(negedge clk);
    rx_v[ch] = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx_v[ch] = data[i];
      repeat (bc) @(negedge clk);
    end
    if (par >= 0) begin
      rx_v[ch] = par[0];
      repeat (bc) @(negedge clk);
    end
    for (int s = 0; s < nstop; s++) begin
      rx_v[ch] = stops[s];
      repeat (bc) @(negedge clk);
    end
  endtask

  task automatic pop(input int ch);
    @(negedge clk);
    rdy[ch] = 1'b1;
    @(negedge clk);
    rdy[ch] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx_v = 3'b111;
    rdy = 3'b000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({d0, pe0, fe0, v0, ov0, cnt0, b0} !== '0) begin n_fail++; $display("FAIL reset_u0: got %h required 0", {d0, pe0, fe0, v0, ov0, cnt0, b0}); end
    n_checks++; if ({d1, pe1, fe1, v1, ov1, cnt1, b1} !== '0) begin n_fail++; $display("FAIL reset_u1: got %h required 0", {d1, pe1, fe1, v1, ov1, cnt1, b1}); end
    n_checks++; if ({d2, pe2, fe2, v2, ov2, cnt2, b2} !== '0) begin n_fail++; $display("FAIL reset_u2: got %h required 0", {d2, pe2, fe2, v2, ov2, cnt2, b2}); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_basic;
    rdy[0] = 1'b1;
    cap_q.delete();
    v0_cycles = 0;
    send(0, 8'h34, 8, -1, 1, 2'b11);
    n_checks++; if (cap_q.size() != 1) begin n_fail++; $display("FAIL basic_pop_by_stop_end: got %0d words required 1", cap_q.size()); end
    repeat (4) @(negedge clk);
    n_checks++; if (cap_q.size() < 1 || cap_q[0] !== 10'h034) begin n_fail++; $display("FAIL basic_word: got %h required 034", (cap_q.size() > 0) ? cap_q[0] : 10'h3ff); end
    n_checks++; if (v0_cycles != 1) begin n_fail++; $display("FAIL basic_valid_width: got %0d cycles required 1", v0_cycles); end
    n_checks++; if (last_pop_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_push: got %b required 0", last_pop_busy); end
    n_checks++; if (cnt0 !== 3'd0) begin n_fail++; $display("FAIL basic_count: got %0d required 0", cnt0); end
    rdy[0] = 1'b0;
  endtask

  task automatic test_back_to_back;
    send(0, 8'h38, 8, -1, 1, 2'b11);
    send(0, 8'h32, 8, -1, 1, 2'b11);
    @(negedge clk);
    n_checks++; if (cnt0 !== 3'd2) begin n_fail++; $display("FAIL b2b_count: got %0d required 2", cnt0); end
    n_checks++; if (d0 !== 8'h38) begin n_fail++; $display("FAIL b2b_head: got %h required 38", d0); end
    cap_q.delete();
    rdy[0] = 1'b1;
    repeat (3) @(negedge clk);
    rdy[0] = 1'b0;
    n_checks++; if (cap_q.size() != 2) begin n_fail++; $display("FAIL b2b_pops: got %0d required 2", cap_q.size()); end
    n_checks++; if (cap_q.size() < 2 || cap_q[0] !== 10'h038 || cap_q[1] !== 10'h032) begin n_fail++; $display("FAIL b2b_order: got %0d words, first %h required 038 then 032", cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : 10'h3ff); end
    n_checks++; if (cnt0 !== 3'd0) begin n_fail++; $display("FAIL b2b_drained: got %0d required 0", cnt0); end
  endtask

  task automatic test_glitch;
    @(negedge clk);
    rx_v[0] = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL glitch_armed: busy %b required 1", b0); end
    repeat (6) @(negedge clk);
    rx_v[0] = 1'b1;
    repeat (42) @(negedge clk);
    n_checks++; if (b0 !== 1'b0) begin n_fail++; $display("FAIL glitch_reject: busy %b required 0", b0); end
    n_checks++; if (cnt0 !== 3'd0) begin n_fail++; $display("FAIL glitch_no_push: count %0d required 0", cnt0); end
    repeat (30) @(negedge clk);
    send(0, 8'h34, 8, -1, 1, 2'b11);
    n_checks++; if (cnt0 !== 3'd1 || {fe0, pe0, d0} !== 10'h034) begin n_fail++; $display("FAIL glitch_next_frame: count %0d word %h required 1 and 034", cnt0, {fe0, pe0, d0}); end
    pop(0);
  endtask

  task automatic test_frame_err;
    send(0, 8'h55, 8, -1, 1, 2'b00);
    rx_v[0] = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (v0 !== 1'b1 || {fe0, pe0, d0} !== 10'h255) begin n_fail++; $display("FAIL ferr_word: valid %b word %h required 1 and 255", v0, {fe0, pe0, d0}); end
    pop(0);
    send(2, 8'h2A, 7, 0, 2, 2'b10);
    repeat (2) @(negedge clk);
    n_checks++; if (v2 !== 1'b1 || {fe2, pe2, d2} !== 9'h12A) begin n_fail++; $display("FAIL ferr_first_stop: valid %b word %h required 1 and 12a", v2, {fe2, pe2, d2}); end
    pop(2);
`ifdef UART_RX_BREAK_EN
    brk_cycles = 0;
    send(0, 8'h00, 8, -1, 1, 2'b00);
    repeat (20) @(negedge clk);
    n_checks++; if (brk_cycles != 1) begin n_fail++; $display("FAIL break_pulse: got %0d cycles required 1", brk_cycles); end
    n_checks++; if (b0 !== 1'b1 || cnt0 !== 3'd0) begin n_fail++; $display("FAIL break_wait: busy %b count %0d required 1 and 0", b0, cnt0); end
    rx_v[0] = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++; if (b0 !== 1'b0 || cnt0 !== 3'd0) begin n_fail++; $display("FAIL break_release: busy %b count %0d required 0 and 0", b0, cnt0); end
`else
    send(0, 8'h00, 8, -1, 1, 2'b00);
    rx_v[0] = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (v0 !== 1'b1 || {fe0, pe0, d0} !== 10'h200) begin n_fail++; $display("FAIL allzero_word: valid %b word %h required 1 and 200", v0, {fe0, pe0, d0}); end
    pop(0);
`endif
  endtask

  task automatic test_parity;
    send(1, 8'h34, 8, 0, 1, 2'b11);
    n_checks++; if ({fe1, pe1, d1} !== 10'h134) begin n_fail++; $display("FAIL even_bad: got %h required 134", {fe1, pe1, d1}); end
    pop(1);
    send(1, 8'h34, 8, 1, 1, 2'b11);
    n_checks++; if ({fe1, pe1, d1} !== 10'h034) begin n_fail++; $display("FAIL even_good: got %h required 034", {fe1, pe1, d1}); end
    pop(1);
    send(2, 8'h34, 7, 0, 2, 2'b11);
    n_checks++; if ({fe2, pe2, d2} !== 9'h034) begin n_fail++; $display("FAIL odd_good: got %h required 034", {fe2, pe2, d2}); end
    pop(2);
    send(2, 8'h34, 7, 1, 2, 2'b11);
    n_checks++; if ({fe2, pe2, d2} !== 9'h0B4) begin n_fail++; $display("FAIL odd_bad: got %h required 0b4", {fe2, pe2, d2}); end
    pop(2);
  endtask

  task automatic test_overrun;
    ov0_cycles = 0;
    for (int k = 1; k <= 4; k++) send(0, 8'(k), 8, -1, 1, 2'b11);
    n_checks++; if (ov0_cycles != 0 || cnt0 !== 3'd4) begin n_fail++; $display("FAIL full_no_overrun: overrun %0d count %0d required 0 and 4", ov0_cycles, cnt0); end
    send(0, 8'h05, 8, -1, 1, 2'b11);
    n_checks++; if (ov0_cycles != 1 || cnt0 !== 3'd4) begin n_fail++; $display("FAIL overrun_pulse: overrun %0d count %0d required 1 and 4", ov0_cycles, cnt0); end
    for (int k = 1; k <= 4; k++) begin
      n_checks++; if (d0 !== 8'(k)) begin n_fail++; $display("FAIL drain_%0d: got %h required %h", k, d0, 8'(k)); end
      pop(0);
    end
    @(negedge clk);
    n_checks++; if (cnt0 !== 3'd0 || v0 !== 1'b0) begin n_fail++; $display("FAIL drain_empty: count %0d valid %b required 0 and 0", cnt0, v0); end
  endtask

  task automatic test_reset_midframe;
    send(0, 8'h66, 8, -1, 1, 2'b11);
    @(negedge clk);
    rx_v[0] = 1'b0;
    repeat (100) @(negedge clk);
    n_checks++; if (b0 !== 1'b1 || cnt0 !== 3'd1) begin n_fail++; $display("FAIL pre_reset: busy %b count %0d required 1 and 1", b0, cnt0); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({d0, pe0, fe0, v0, ov0, cnt0, b0} !== '0) begin n_fail++; $display("FAIL midframe_reset: got %h required 0", {d0, pe0, fe0, v0, ov0, cnt0, b0}); end
    repeat (64) @(negedge clk);
    n_checks++; if (b0 !== 1'b0) begin n_fail++; $display("FAIL low_at_release: busy %b required 0", b0); end
    rx_v[0] = 1'b1;
    repeat (64) @(negedge clk);
    send(0, 8'h5A, 8, -1, 1, 2'b11);
    n_checks++; if (cnt0 !== 3'd1 || {fe0, pe0, d0} !== 10'h05A) begin n_fail++; $display("FAIL post_reset_frame: count %0d word %h required 1 and 05a", cnt0, {fe0, pe0, d0}); end
    pop(0);
    n_checks++; if (other_ov != 0) begin n_fail++; $display("FAIL stray_overrun: got %0d required 0", other_ov); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_parity();
    test_overrun();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised successor to the fixed 8N1/9600 UART receiver.
- Generic clock/baud, data width 5-8, parity none/even/odd, 1 or 2 stop bits.
- 16x (configurable) oversampling with 3-sample majority vote and start-bit glitch rejection.
- Received words, with per-word error flags, are buffered in a small show-ahead FIFO with a valid/ready handshake toward the decode/7-seg logic in TOP.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s
DATA_BITS, 8, data bits per frame (5..8)
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits checked (1 or 2)
OVERSAMPLE, 16, sample ticks per bit (even, >= 8)
FIFO_DEPTH, 4, receive FIFO entries (power of 2, >= 2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
rx  in  1  asynchronous serial line, idle high
rx_data  out  DATA_BITS  FIFO head data, LSB = first bit received
rx_parity_err  out  1  FIFO head parity error flag (always 0 when PARITY = 0)
rx_frame_err  out  1  FIFO head framing error flag
rx_valid  out  1  FIFO not empty
rx_ready  in  1  consumer accepts head; pop when rx_valid & rx_ready
overrun  out  1  one-cycle pulse when a completed word is dropped
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
busy  out  1  receiver state is not IDLE

Behaviour:
- Reset values (one cycle of rst = 1):
  - All outputs 0.
  - FIFO emptied; state IDLE; tick divider and sample counters 0.
  - rx synchroniser flops set to 1; edge-detect register set to 0.
- Reset mid-frame aborts the frame with no push.
- Because the edge register resets to 0, a line already low at reset release is not a start edge. Only a 1->0 transition arms the receiver.
- Tick divider:
  - DIV = (CLK_HZ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE), i.e. 326 for the defaults.
  - Counter runs 0..DIV-1 and issues a one-cycle tick at DIV-1.
  - Counter is cleared on start-edge detection so the bit phase is re-aligned per frame.
- rx passes through a 2-flop synchroniser. All decisions use the synchronised value.
- Bit sampling: the sample counter runs 0..OVERSAMPLE-1 per bit. The bit value is the majority of samples at OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
- State machine:
  - IDLE: falling edge -> START.
  - START: at the mid-bit decision, majority 1 -> IDLE (glitch, nothing pushed); else continue to end of bit -> DATA.
  - DATA: DATA_BITS bits shifted in LSB-first. After the last bit -> PARITY if PARITY != 0, else STOP.
  - PARITY: sampled bit compared with the computed parity; mismatch sets parity_err.
    - Even: XOR of data bits and parity bit must be 0.
    - Odd: that XOR must be 1.
  - STOP: each stop bit majority must be 1, else frame_err is set.
    - At the mid-sample decision of the last stop bit, the word is pushed and the state goes to IDLE. There is no wait for the bit end, so the receiver can resync on the next edge.
- Push latency: rx_valid rises 1 clk after the last-stop-bit mid-sample tick when the FIFO was empty.
- FIFO:
  - Entries hold {frame_err, parity_err, data}.
  - Show-ahead: the head is presented combinationally from storage while rx_valid = 1.
  - Push while full and no pop: word dropped, overrun pulses for 1 cycle, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both occur, no overrun, count unchanged.
  - Push and pop in the same cycle while empty: push only (pop requires rx_valid). count goes 0 -> 1.
  - Pointers wrap modulo FIFO_DEPTH. fifo_count is exact 0..FIFO_DEPTH.
- Error words are still pushed with their flags. No error halts the receiver.

Optional Feature:
UART_RX_BREAK_EN
- Defined: adds output port break_det (1 bit, reset 0).
  - Trigger: a frame whose data bits are all 0, parity bit (if any) is 0, and stop sample is 0.
  - Effect: break_det pulses for 1 cycle, nothing is pushed, and the receiver stays in a WAIT_IDLE state until synchronised rx is 1, then returns to IDLE.
- Undefined: port and WAIT_IDLE state are absent. Such a frame is pushed as data 0 with frame_err = 1.

Test Plan:
1. Defaults, rx_ready = 1; send 0x34 (bit period 104167 ns, LSB first 0,0,1,0,1,1,0,0, stop 1) -> rx_valid pulses 1 cycle; rx_data = 0x34; both error flags 0; busy falls at mid-stop.
2. rx_ready = 0; send 0x38 then 0x32 back-to-back (20 ns gap) -> fifo_count = 2. Raise rx_ready -> pops 0x38 then 0x32; count returns to 0.
3. Glitch: rx low for 3 ticks (~2 x 9.8 us... 3 x 6.52 us), then high -> no push; busy returns to 0 before bit end. A valid 0x34 sent next is received correctly.
4. Stop bit driven 0 on 0x55 -> word 0x55 with rx_frame_err = 1. With UART_RX_BREAK_EN, an all-low 0x00 frame instead gives a break_det pulse and no push until rx returns high.
5. PARITY = 1; send 0x34 with parity bit 0 (correct bit is 1) -> rx_parity_err = 1. Resend with parity 1 -> flag 0. PARITY = 2 with parity 0 -> flag 0.
6. FIFO_DEPTH = 4, rx_ready = 0; send 5 frames 0x01..0x05 -> overrun pulse at the 5th; count = 4; drain yields 0x01..0x04. Then assert rst mid-frame -> all outputs 0, FIFO empty, next frame received normally.
